// File: rtl/alu_pkg.sv
// Shared ALU result types: opcode enum, flag struct, buffered result record
// and flag bit positions within the 5-bit flag vector.
package alu_pkg;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_XOR = 2'b11
  } alu_op_t;

  typedef struct packed {
    logic parity;
    logic overflow;
    logic greater;
    logic is_eq;
    logic less;
  } alu_flags_t;

  typedef struct packed {
    alu_op_t    op;
    logic [7:0] y;
    alu_flags_t flags;
  } alu_res_t;

  localparam int FLAG_LESS  = 0;
  localparam int FLAG_EQ    = 1;
  localparam int FLAG_GT    = 2;
  localparam int FLAG_OVF   = 3;
  localparam int FLAG_PAR   = 4;

  localparam int RES_W = $bits(alu_res_t);

endpackage

// File: rtl/resbuf_fifo.sv
// Registered-read FIFO storage for alu_result_buffer: pointers, occupancy and
// a copy of the last popped word so the head stays defined while empty.
module resbuf_fifo #(
  parameter int W     = 15,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             wdata,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] count_q, count_d;
  logic [W-1:0]  last_q, last_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == LW'(DEPTH));
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = empty ? last_q : mem_q[rd_ptr_q];

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    last_d   = last_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      last_d   = mem_q[rd_ptr_q];
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + LW'(1);
      2'b01:   count_d = count_q - LW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q gates visibility so stale words are never read.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/alu_result_buffer.sv
// Valid/ready FIFO buffering ALU results; optional push statistics counters
// are built only when ALU_RESBUF_STATS_EN is defined.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_op,
  input  logic [7:0]             in_y,
  input  logic [4:0]             in_flags,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [1:0]             out_op,
  output logic [7:0]             out_y,
  output logic [4:0]             out_flags,
`ifdef ALU_RESBUF_STATS_EN
  input  logic                   stat_clr,
  output logic [CNT_W-1:0]       ovf_cnt,
  output logic [CNT_W-1:0]       eq_cnt,
`endif
  output logic [$clog2(DEPTH):0] level
);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_bad_param
    $error("alu_result_buffer: DEPTH must be a power of 2 in 2..16 and CNT_W >= 1");
  end

  alu_res_t wr_res, head;
  logic     full, empty, push, pop;

  assign wr_res    = '{op: alu_op_t'(in_op), y: in_y, flags: alu_flags_t'(in_flags)};
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_op    = head.op;
  assign out_y     = head.y;
  assign out_flags = head.flags;

  resbuf_fifo #(
    .W     (RES_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (wr_res),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

`ifdef ALU_RESBUF_STATS_EN
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;

  // Counters saturate at all-ones; a clear overrides any increment in the same cycle.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    eq_cnt_d  = eq_cnt_q;
    if (stat_clr) begin
      ovf_cnt_d = '0;
      eq_cnt_d  = '0;
    end else if (push) begin
      if (in_flags[FLAG_OVF] && ovf_cnt_q != '1) ovf_cnt_d = ovf_cnt_q + CNT_W'(1);
      if (in_flags[FLAG_EQ]  && eq_cnt_q  != '1) eq_cnt_d  = eq_cnt_q  + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_cnt_q <= '0;
      eq_cnt_q  <= '0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
      eq_cnt_q  <= eq_cnt_d;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
  assign eq_cnt  = eq_cnt_q;
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Self-checking bench for alu_result_buffer against a queue-based reference
// model; statistics scenarios compile only with ALU_RESBUF_STATS_EN.
module tb_alu_result_buffer;

  localparam int DEPTH = 4;
  localparam int CNT_W = 8;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [7:0]       in_y;
  logic [4:0]       in_flags;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_op;
  logic [7:0]       out_y;
  logic [4:0]       out_flags;
  logic [LW-1:0]    level;
`ifdef ALU_RESBUF_STATS_EN
  logic             stat_clr;
  logic [CNT_W-1:0] ovf_cnt;
  logic [CNT_W-1:0] eq_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: a queue of {op, y, flags} words plus the last popped word.
  logic [14:0] mdl_q[$];
  logic [14:0] mdl_last;
  int          mdl_ovf;
  int          mdl_eq;

  always #5 clk = ~clk;

  alu_result_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_y      (in_y),
    .in_flags  (in_flags),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_op    (out_op),
    .out_y     (out_y),
    .out_flags (out_flags),
`ifdef ALU_RESBUF_STATS_EN
    .stat_clr  (stat_clr),
    .ovf_cnt   (ovf_cnt),
    .eq_cnt    (eq_cnt),
`endif
    .level     (level)
  );

  // Advance one clock, updating the model from the inputs presented before the edge.
  task automatic cycle();
    bit          push_ok, pop_ok, clr;
    logic [14:0] word;
    push_ok = in_valid && (mdl_q.size() < DEPTH);
    pop_ok  = out_ready && (mdl_q.size() > 0);
    word    = {in_op, in_y, in_flags};
    clr     = 1'b0;
`ifdef ALU_RESBUF_STATS_EN
    clr     = stat_clr;
`endif
    @(posedge clk);
    if (rst) begin
      mdl_q.delete();
      mdl_last = '0;
      mdl_ovf  = 0;
      mdl_eq   = 0;
    end else begin
      if (pop_ok) mdl_last = mdl_q.pop_front();
      if (push_ok) mdl_q.push_back(word);
      if (clr) begin
        mdl_ovf = 0;
        mdl_eq  = 0;
      end else if (push_ok) begin
        if (word[3] && mdl_ovf < CMAX) mdl_ovf++;
        if (word[1] && mdl_eq  < CMAX) mdl_eq++;
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_op     = '0;
    in_y      = '0;
    in_flags  = '0;
`ifdef ALU_RESBUF_STATS_EN
    stat_clr  = 1'b0;
`endif
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  task automatic push_one(input logic [7:0] y);
    in_valid = 1'b1;
    in_y     = y;
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    in_valid = 1'b1;
    in_y     = 8'hEE;
    rst      = 1'b1;
    cycle();
    rst = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({out_valid, in_ready, level} !== {1'b0, 1'b1, LW'(0)}) begin
      errors++;
      $display("FAIL reset_handshake: out_valid=%0b in_ready=%0b level=%0d, required 0/1/0", out_valid, in_ready, level);
    end
    checks++;
    if ({out_op, out_y, out_flags} !== 15'd0) begin
      errors++;
      $display("FAIL reset_fields: op=%0h y=%0h flags=%0h, required all 0", out_op, out_y, out_flags);
    end
  endtask

  task automatic test_single();
    do_reset();
    in_valid = 1'b1;
    in_op    = 2'b00;
    in_y     = 8'h5A;
    in_flags = 5'b10000;
    cycle();
    in_valid = 1'b0;
    checks++;
    if ({out_valid, out_y, out_flags, level} !== {1'b1, 8'h5A, 5'b10000, LW'(1)}) begin
      errors++;
      $display("FAIL single_push: out_valid=%0b y=%0h flags=%b level=%0d, required 1/5a/10000/1", out_valid, out_y, out_flags, level);
    end
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int i = 1; i <= 4; i++) push_one(8'(i));
    checks++;
    if ({level, in_ready} !== {LW'(4), 1'b0}) begin
      errors++;
      $display("FAIL fill_full: level=%0d in_ready=%0b, required 4/0", level, in_ready);
    end
    push_one(8'h05);
    checks++;
    if ({level, out_y} !== {LW'(4), 8'h01}) begin
      errors++;
      $display("FAIL fill_fifth_ignored: level=%0d head=%0h, required 4/01", level, out_y);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if ({out_valid, out_y} !== {1'b1, 8'(i)}) begin
        errors++;
        $display("FAIL drain_order[%0d]: out_valid=%0b y=%0h, required 1/%0h", i, out_valid, out_y, i);
      end
      cycle();
    end
    out_ready = 1'b0;
    checks++;
    if ({out_valid, out_y, level} !== {1'b0, 8'h04, LW'(0)}) begin
      errors++;
      $display("FAIL drain_empty_hold: out_valid=%0b y=%0h level=%0d, required 0/04/0", out_valid, out_y, level);
    end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 4; i++) push_one(8'h10 + 8'(i));
    in_valid  = 1'b1;
    in_y      = 8'h20;
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_in_ready: in_ready=%0b, required 0", in_ready);
    end
    cycle();
    checks++;
    if ({level, out_y} !== {LW'(3), 8'h11}) begin
      errors++;
      $display("FAIL full_pop_refuse: level=%0d head=%0h, required 3/11", level, out_y);
    end
    out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    checks++;
    if (level !== LW'(4)) begin
      errors++;
      $display("FAIL full_repush: level=%0d, required 4", level);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_y !== ((i == 3) ? 8'h20 : 8'h11 + 8'(i))) begin
        errors++;
        $display("FAIL full_drain[%0d]: y=%0h", i, out_y);
      end
      cycle();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    push_one(8'h30);
    push_one(8'h31);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_y = 8'h32 + 8'(i);
      checks++;
      if (out_y !== 8'h30 + 8'(i)) begin
        errors++;
        $display("FAIL b2b_order[%0d]: y=%0h required %0h", i, out_y, 8'h30 + 8'(i));
      end
      cycle();
      checks++;
      if (level !== LW'(2)) begin
        errors++;
        $display("FAIL b2b_level[%0d]: level=%0d required 2", i, level);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) push_one(8'h40 + 8'(i));
    in_valid = 1'b1;
    in_y     = 8'h77;
    in_flags = 5'b01010;
    rst      = 1'b1;
    cycle();
    rst = 1'b0;
    in_valid = 1'b0;
    checks++;
    if ({level, out_valid, in_ready, out_op, out_y, out_flags} !== {LW'(0), 1'b0, 1'b1, 15'd0}) begin
      errors++;
      $display("FAIL reset_mid: level=%0d out_valid=%0b y=%0h, required 0/0/0", level, out_valid, out_y);
    end
`ifdef ALU_RESBUF_STATS_EN
    checks++;
    if ({ovf_cnt, eq_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_mid_cnt: ovf=%0d eq=%0d, required 0/0", ovf_cnt, eq_cnt);
    end
`endif
  endtask

`ifdef ALU_RESBUF_STATS_EN
  task automatic test_stats();
    do_reset();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_flags  = 5'b01010;
    for (int i = 0; i < 300; i++) begin
      in_y = 8'(i);
      cycle();
    end
    checks++;
    if ({ovf_cnt, eq_cnt} !== {CNT_W'(CMAX), CNT_W'(CMAX)}) begin
      errors++;
      $display("FAIL stats_saturate: ovf=%0d eq=%0d, required %0d", ovf_cnt, eq_cnt, CMAX);
    end
    stat_clr = 1'b1;
    cycle();
    stat_clr = 1'b0;
    checks++;
    if ({ovf_cnt, eq_cnt} !== '0) begin
      errors++;
      $display("FAIL stats_clear_wins: ovf=%0d eq=%0d, required 0", ovf_cnt, eq_cnt);
    end
    idle_inputs();
  endtask
`endif

  task automatic test_random();
    logic [14:0] exp_head;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 60) == 0);
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      in_op     = 2'($urandom);
      in_y      = 8'($urandom);
      in_flags  = 5'($urandom);
`ifdef ALU_RESBUF_STATS_EN
      stat_clr  = ($urandom_range(0, 40) == 0);
`endif
      cycle();
      exp_head = (mdl_q.size() > 0) ? mdl_q[0] : mdl_last;
      checks++;
      if ({out_valid, in_ready, level, out_op, out_y, out_flags} !==
          {mdl_q.size() > 0, mdl_q.size() < DEPTH, LW'(mdl_q.size()), exp_head}) begin
        errors++;
        $display("FAIL random[%0d]: valid=%0b ready=%0b level=%0d head=%0h, required %0b/%0b/%0d/%0h", n,
                 out_valid, in_ready, level, {out_op, out_y, out_flags},
                 mdl_q.size() > 0, mdl_q.size() < DEPTH, mdl_q.size(), exp_head);
      end
`ifdef ALU_RESBUF_STATS_EN
      checks++;
      if ({ovf_cnt, eq_cnt} !== {CNT_W'(mdl_ovf), CNT_W'(mdl_eq)}) begin
        errors++;
        $display("FAIL random_cnt[%0d]: ovf=%0d eq=%0d, required %0d/%0d", n, ovf_cnt, eq_cnt, mdl_ovf, mdl_eq);
      end
`endif
    end
    rst = 1'b0;
    idle_inputs();
  endtask

  initial begin
    mdl_last = '0;
    mdl_ovf  = 0;
    mdl_eq   = 0;
    rst      = 1'b0;
    idle_inputs();
    #2;
    test_reset();
    test_single();
    test_fill_drain();
    test_full_push_pop();
    test_back_to_back();
`ifdef ALU_RESBUF_STATS_EN
    test_stats();
`endif
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
